// File: rtl/register_file_16x32.sv
//------------------------------------------------------------------------------
// register_file_16x32 : 16 x WIDTH register file, one-hot active-low write
// select, two combinational read ports, sticky multi-select error flag.
// Optional macro RF_BYPASS_EN adds write-first read bypass.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module register_file_16x32 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0]      E_n,
   input  logic             RW,
   input  logic [WIDTH-1:0] PD,
   input  logic [3:0]       SA,
   input  logic [3:0]       SB,
   input  logic             err_clr,
   output logic [WIDTH-1:0] PA,
   output logic [WIDTH-1:0] PB,
   output logic             err
);

   localparam int NUM_REGS = 16;

   logic [WIDTH-1:0] regs_q [NUM_REGS];
   logic [WIDTH-1:0] regs_d [NUM_REGS];
   logic             err_q;
   logic             err_d;

   logic [15:0]      sel;
   logic             sel_any;
   logic             sel_multi;
   logic             wr_legal;
   logic [3:0]       wr_idx;

   // More than one bit set exactly when clearing the lowest set bit leaves a remainder.
   assign sel       = ~E_n;
   assign sel_any   = |sel;
   assign sel_multi = |(sel & (sel - 16'd1));
   assign wr_legal  = RW && sel_any && !sel_multi;

   always_comb begin
      wr_idx = 4'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (sel[i]) begin
            wr_idx = 4'(i);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (wr_legal) begin
         regs_d[wr_idx] = PD;
      end
   end

   // A new multi-select at the same edge as err_clr keeps the flag set.
   always_comb begin
      err_d = err_q;
      if (err_clr) begin
         err_d = 1'b0;
      end
      if (RW && sel_multi) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
         err_q <= err_d;
      end
   end

`ifdef RF_BYPASS_EN
   logic bypass_ok;
   assign bypass_ok = wr_legal && rst_n;

   always_comb begin
      PA = regs_q[SA];
      PB = regs_q[SB];
      if (bypass_ok && (wr_idx == SA)) begin
         PA = PD;
      end
      if (bypass_ok && (wr_idx == SB)) begin
         PB = PD;
      end
   end
`else
   always_comb begin
      PA = regs_q[SA];
      PB = regs_q[SB];
   end
`endif

   assign err = err_q;

endmodule

`default_nettype wire

// File: doc/register_file_16x32.md
REGISTER_FILE_16X32 -- requirements
Module: register_file_16x32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every register and data port.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port E_n  input  16  active-low one-hot register write select from the 4x16 negative-logic decoder; bit i low selects Ri.
REQ-005 SHALL have port RW  input  1  active-high global write strobe.
REQ-006 SHALL have port PD  input  WIDTH  write data.
REQ-007 SHALL have port SA  input  4  read select, port A.
REQ-008 SHALL have port SB  input  4  read select, port B.
REQ-009 SHALL have port err_clr  input  1  active-high synchronous clear of err.
REQ-010 SHALL have port PA  output  WIDTH  contents of R[SA].
REQ-011 SHALL have port PB  output  WIDTH  contents of R[SB].
REQ-012 SHALL have port err  output  1  sticky flag: multi-select write attempted.

Function
REQ-013 SHALL hold 16 registers R0..R15 of WIDTH bits; all are general-purpose, none hardwired.
REQ-014 SHALL, at a rising clk edge with RW=1 and exactly one E_n bit low (bit i), load R[i] <= PD; all other registers hold.
REQ-015 SHALL, with RW=1 and E_n = 16'hFFFF, write nothing and leave err unchanged.
REQ-016 SHALL, with RW=1 and two or more E_n bits low, write no register and set err=1 at that edge.
REQ-017 SHALL, with RW=0, ignore E_n entirely: no write, no err evaluation.
REQ-018 SHALL drive PA = R[SA] and PB = R[SB] combinationally, zero-cycle latency; SA = SB is legal, and both ports return the same value.
REQ-019 SHALL make written data visible on PA/PB from the cycle after the write edge (one-cycle write-to-read latency) when RF_BYPASS_EN is undefined.
REQ-020 SHALL hold err=1 until err_clr=1 at a clock edge or reset; if err_clr=1 and a new multi-select occur at the same edge, err SHALL remain 1 (set wins).
REQ-021 SHALL keep err, once set, unaffected by subsequent legal writes.
REQ-022 SHALL keep write behaviour independent of SA/SB and of read activity.

Reset
REQ-023 SHALL, on rst_n low, asynchronously clear R0..R15 to 0 and err to 0, without waiting for clk.
REQ-024 SHALL discard any write whose edge coincides with rst_n low; reset has priority over RW, E_n and err_clr.
REQ-025 SHALL resume normal operation at the first rising clk edge after rst_n deasserts; PA/PB read 0 while in reset.

Configuration
REQ-026 SHALL support macro RF_BYPASS_EN; when defined, a read port whose select equals the register being legally written this cycle (RW=1, one-hot E_n) SHALL return PD combinationally (write-first).
REQ-027 SHALL, with RF_BYPASS_EN defined, not bypass on multi-select or all-ones E_n, or during reset; register update timing is unchanged.
REQ-028 SHALL, with RF_BYPASS_EN undefined, contain no bypass path; PA/PB reflect stored contents only.

Verification
REQ-029 SHALL cover reset: write R3=32'hDEADBEEF, assert rst_n=0 mid-cycle -> PA(SA=3)=0 immediately, err=0.
REQ-030 SHALL cover legal write: RW=1, E_n=16'hFFF7, PD=32'h12345678, SA=3 -> PA=0 before edge, 32'h12345678 after edge (bypass undefined).
REQ-031 SHALL cover multi-select: R5=32'hA5A5A5A5, R6=0; RW=1, E_n=16'hFF9F, PD=32'hFFFFFFFF -> R5/R6 unchanged, err=1 after edge.
REQ-032 SHALL cover err priority: err=1, then err_clr=1 with another multi-select same edge -> err stays 1; next edge err_clr=1, RW=0 -> err=0.
REQ-033 SHALL cover RW gating: RW=0, E_n=16'h0000, PD=32'h1 -> no register changes, err stays 0.
REQ-034 SHALL cover bypass (RF_BYPASS_EN defined): RW=1, E_n=16'h7FFF, PD=32'hCAFEF00D, SA=SB=15 -> PA=PB=32'hCAFEF00D before edge; with E_n=16'h7FFE, PA=PB=old R15.
